// File: rtl/nx_mem_typePKG.sv
// Shared types for the nx_*_indirect_access memory command protocol.
// Holds the command opcode enum, the status code enum and the LOG_VEC
// helper used to size entry address ports.
// No ports (package).
package nx_mem_typePKG;

  typedef enum logic [3:0] {
    MEM_OP_NOP   = 4'h0,
    MEM_OP_READ  = 4'h1,
    MEM_OP_WRITE = 4'h2
  } mem_op_e;

  typedef enum logic [2:0] {
    MEM_STAT_OK   = 3'd0,
    MEM_STAT_BUSY = 3'd1
  } mem_stat_e;

  // Address width for a memory of n entries; a single-entry memory
  // still gets a one-bit address so ports never collapse to zero width.
  function automatic int unsigned log_vec(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nx_initiator_poll_timer.sv
// Saturating poll timeout counter for nx_indirect_access_initiator.
// Only instantiated when NX_INDIRECT_INITIATOR_TIMEOUT_EN is defined.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : zero the counter (asserted while the command strobe issues)
//   count_i       : advance the counter (asserted on every poll cycle)
//   expired_o     : counter has saturated at all-ones
module nx_initiator_poll_timer #(
  parameter int unsigned N_TIMER_BITS = 6
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic count_i,
  output logic expired_o
);

  logic [N_TIMER_BITS-1:0] cnt_q;
  logic [N_TIMER_BITS-1:0] cnt_d;

  // The counter holds at all-ones so expiry stays asserted until cleared.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_i && !(&cnt_q)) begin
      cnt_d = cnt_q + N_TIMER_BITS'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = &cnt_q;

endmodule

// File: rtl/nx_indirect_access_initiator.sv
// Register-side initiator for the nx_*_indirect_access memory protocol.
// Accepts one request at a time, then sequences data-register write,
// command strobe, status poll and data-register read, and returns one
// response per request. All outputs are registered.
// Optional feature: define NX_INDIRECT_INITIATOR_TIMEOUT_EN to bound the
// status poll with an N_TIMER_BITS saturating counter; otherwise the poll
// waits indefinitely and rsp_timeout_o stays 0.
// Ports:
//   clk_i, rst_ni                     : clock, asynchronous active-low reset
//   req_valid_i/req_ready_o           : request handshake
//   req_op_i/req_addr_i/req_wdata_i   : request opcode, entry address, write data
//   rsp_valid_o/rsp_ready_i           : response handshake
//   rsp_rdata_o/rsp_code_o            : read data (0 for non-reads), final status
//   rsp_timeout_o                     : poll timed out
//   reg_addr_o/wr_stb_o/wr_dat_o      : register access to the memory wrapper
//   cmnd_op_o/cmnd_addr_o             : latched command fields
//   stat_code_i/rd_dat_i              : wrapper status and data register
module nx_indirect_access_initiator
  import nx_mem_typePKG::*;
#(
  parameter int unsigned CMND_ADDRESS    = 0,
  parameter int unsigned STAT_ADDRESS    = 0,
  parameter int unsigned DATA_ADDRESS    = 0,
  parameter int unsigned N_REG_ADDR_BITS = 16,
  parameter int unsigned N_DATA_BITS     = 32,
  parameter int unsigned N_ENTRIES       = 1,
  parameter int unsigned N_TIMER_BITS    = 6
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              req_valid_i,
  output logic                              req_ready_o,
  input  logic [3:0]                        req_op_i,
  input  logic [log_vec(N_ENTRIES)-1:0]     req_addr_i,
  input  logic [N_DATA_BITS-1:0]            req_wdata_i,
  output logic                              rsp_valid_o,
  input  logic                              rsp_ready_i,
  output logic [N_DATA_BITS-1:0]            rsp_rdata_o,
  output logic [2:0]                        rsp_code_o,
  output logic                              rsp_timeout_o,
  output logic [N_REG_ADDR_BITS-1:0]        reg_addr_o,
  output logic                              wr_stb_o,
  output logic [N_DATA_BITS-1:0]            wr_dat_o,
  output logic [3:0]                        cmnd_op_o,
  output logic [log_vec(N_ENTRIES)-1:0]     cmnd_addr_o,
  input  logic [2:0]                        stat_code_i,
  input  logic [N_DATA_BITS-1:0]            rd_dat_i
);

  localparam int unsigned ADDR_BITS = log_vec(N_ENTRIES);
  localparam logic [N_REG_ADDR_BITS-1:0] REG_CMND = N_REG_ADDR_BITS'(CMND_ADDRESS);
  localparam logic [N_REG_ADDR_BITS-1:0] REG_STAT = N_REG_ADDR_BITS'(STAT_ADDRESS);
  localparam logic [N_REG_ADDR_BITS-1:0] REG_DATA = N_REG_ADDR_BITS'(DATA_ADDRESS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_CMND,
    ST_POLL,
    ST_RDATA,
    ST_RESP
  } state_e;

  state_e                     state_q;
  logic                       settle_q;
  logic                       req_ready_q;
  logic                       rsp_valid_q;
  logic [N_DATA_BITS-1:0]     rsp_rdata_q;
  logic [2:0]                 rsp_code_q;
  logic                       rsp_timeout_q;
  logic [N_REG_ADDR_BITS-1:0] reg_addr_q;
  logic                       wr_stb_q;
  logic [N_DATA_BITS-1:0]     wr_dat_q;
  logic [3:0]                 cmnd_op_q;
  logic [ADDR_BITS-1:0]       cmnd_addr_q;
  logic                       timer_expired;

`ifdef NX_INDIRECT_INITIATOR_TIMEOUT_EN
  // Cleared while the command strobe issues, so it reads 0 in the settle
  // cycle and k in the k-th poll cycle after it.
  nx_initiator_poll_timer #(
    .N_TIMER_BITS(N_TIMER_BITS)
  ) u_poll_timer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (state_q == ST_CMND),
    .count_i  (state_q == ST_POLL),
    .expired_o(timer_expired)
  );
`else
  assign timer_expired = 1'b0;
`endif

  // Outputs are computed one state ahead so each register already holds
  // the value for the state being entered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      settle_q      <= 1'b0;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_code_q    <= '0;
      rsp_timeout_q <= 1'b0;
      reg_addr_q    <= '0;
      wr_stb_q      <= 1'b0;
      wr_dat_q      <= '0;
      cmnd_op_q     <= '0;
      cmnd_addr_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            req_ready_q <= 1'b0;
            cmnd_op_q   <= req_op_i;
            cmnd_addr_q <= req_addr_i;
            wr_stb_q    <= 1'b1;
            if (req_op_i == MEM_OP_WRITE) begin
              state_q    <= ST_WDATA;
              reg_addr_q <= REG_DATA;
              wr_dat_q   <= req_wdata_i;
            end else begin
              state_q    <= ST_CMND;
              reg_addr_q <= REG_CMND;
              wr_dat_q   <= '0;
            end
          end
        end
        ST_WDATA: begin
          state_q    <= ST_CMND;
          reg_addr_q <= REG_CMND;
          wr_stb_q   <= 1'b1;
          wr_dat_q   <= '0;
        end
        ST_CMND: begin
          state_q    <= ST_POLL;
          reg_addr_q <= REG_STAT;
          wr_stb_q   <= 1'b0;
          settle_q   <= 1'b1;
        end
        ST_POLL: begin
          settle_q <= 1'b0;
          // The wrapper status is not yet valid in the settle cycle.
          if (!settle_q) begin
            if (stat_code_i != MEM_STAT_BUSY) begin
              rsp_code_q    <= stat_code_i;
              rsp_rdata_q   <= '0;
              rsp_timeout_q <= 1'b0;
              if ((cmnd_op_q == MEM_OP_READ) && (stat_code_i == MEM_STAT_OK)) begin
                state_q    <= ST_RDATA;
                reg_addr_q <= REG_DATA;
              end else begin
                state_q     <= ST_RESP;
                rsp_valid_q <= 1'b1;
              end
            end else if (timer_expired) begin
              state_q       <= ST_RESP;
              rsp_valid_q   <= 1'b1;
              rsp_code_q    <= stat_code_i;
              rsp_rdata_q   <= '0;
              rsp_timeout_q <= 1'b1;
            end
          end
        end
        ST_RDATA: begin
          state_q     <= ST_RESP;
          rsp_rdata_q <= rd_dat_i;
          rsp_valid_q <= 1'b1;
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o   = req_ready_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_code_o    = rsp_code_q;
  assign rsp_timeout_o = rsp_timeout_q;
  assign reg_addr_o    = reg_addr_q;
  assign wr_stb_o      = wr_stb_q;
  assign wr_dat_o      = wr_dat_q;
  assign cmnd_op_o     = cmnd_op_q;
  assign cmnd_addr_o   = cmnd_addr_q;

endmodule

// File: tb/tb_nx_indirect_access_initiator.sv
// Self-checking bench for nx_indirect_access_initiator. A transaction-level
// model expands each request into the register-access trace it must
// produce and the response it must return; one compare process checks
// the DUT against that trace on every cycle.
module tb_nx_indirect_access_initiator;

  localparam logic [15:0] CMND_A = 16'h0010;
  localparam logic [15:0] STAT_A = 16'h0014;
  localparam logic [15:0] DATA_A = 16'h0018;
  localparam int TIMER_BITS = 3;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic [3:0]  reqOp = '0;
  logic [3:0]  reqAddr = '0;
  logic [31:0] reqWdata = '0;
  logic        rspValid;
  logic        rspReady = 1'b0;
  logic [31:0] rspRdata;
  logic [2:0]  rspCode;
  logic        rspTimeout;
  logic [15:0] regAddr;
  logic        wrStb;
  logic [31:0] wrDat;
  logic [3:0]  cmndOp;
  logic [3:0]  cmndAddr;
  logic [2:0]  statCode = '0;
  logic [31:0] rdDat = '0;

  nx_indirect_access_initiator #(
    .CMND_ADDRESS   (32'h0010),
    .STAT_ADDRESS   (32'h0014),
    .DATA_ADDRESS   (32'h0018),
    .N_REG_ADDR_BITS(16),
    .N_DATA_BITS    (32),
    .N_ENTRIES      (16),
    .N_TIMER_BITS   (TIMER_BITS)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rstN),
    .req_valid_i  (reqValid),
    .req_ready_o  (reqReady),
    .req_op_i     (reqOp),
    .req_addr_i   (reqAddr),
    .req_wdata_i  (reqWdata),
    .rsp_valid_o  (rspValid),
    .rsp_ready_i  (rspReady),
    .rsp_rdata_o  (rspRdata),
    .rsp_code_o   (rspCode),
    .rsp_timeout_o(rspTimeout),
    .reg_addr_o   (regAddr),
    .wr_stb_o     (wrStb),
    .wr_dat_o     (wrDat),
    .cmnd_op_o    (cmndOp),
    .cmnd_addr_o  (cmndAddr),
    .stat_code_i  (statCode),
    .rd_dat_i     (rdDat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  addr;
    logic [31:0] wdata;
    int          busy;
    logic [2:0]  finalCode;
    logic [31:0] rdData;
    int          respDelay;
  } reqT;

  // One expected cycle of register traffic, plus what the bench presents
  // on stat_code/rd_dat during that cycle.
  typedef struct {
    logic [15:0] addr;
    logic        stb;
    logic        chkDat;
    logic [31:0] dat;
    logic [2:0]  stat;
    logic [31:0] rd;
  } recT;

  reqT reqQ[$];
  recT expQ[$];

  int checks = 0;
  int errors = 0;

  logic        busy = 1'b0;
  logic [3:0]  lastOp = '0;
  logic [3:0]  lastAddr = '0;
  logic [31:0] expRdata = '0;
  logic [2:0]  expCode = '0;
  logic        expTimeout = 1'b0;
  int          expRespDelay = 0;
  int          respCycles = 0;
  int          cyc = 0;
  int          acceptCyc = 0;
  int          latency = 0;
  int          lastHandshakeCyc = 0;
  int          lastGap = 0;
  logic [31:0] seenRdata = '0;
  logic [2:0]  seenCode = '0;
  logic        seenTimeout = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input reqT r);
    reqQ.push_back(r);
  endtask

  // Expand a request into its expected register trace and response.
  function automatic void buildTrace(input reqT r);
    int nPoll;
    logic tmo;
    logic [2:0] st;
    logic [2:0] code;
    recT rec;
    expQ.delete();
    if (r.op == 4'h2) begin
      rec = '{DATA_A, 1'b1, 1'b1, r.wdata, 3'($urandom), $urandom};
      expQ.push_back(rec);
    end
    rec = '{CMND_A, 1'b1, 1'b0, 32'h0, 3'($urandom), $urandom};
    expQ.push_back(rec);
    nPoll = 2 + r.busy;
    tmo = 1'b0;
`ifdef NX_INDIRECT_INITIATOR_TIMEOUT_EN
    if (nPoll > (1 << TIMER_BITS)) begin
      nPoll = 1 << TIMER_BITS;
      tmo = 1'b1;
    end
`endif
    code = 3'd0;
    for (int k = 0; k < nPoll; k++) begin
      if (k == 0) st = 3'($urandom);
      else if (k <= r.busy) st = 3'd1;
      else st = r.finalCode;
      rec = '{STAT_A, 1'b0, 1'b1, 32'h0, st, $urandom};
      expQ.push_back(rec);
      code = st;
    end
    expCode = code;
    expTimeout = tmo;
    expRdata = 32'h0;
    if ((r.op == 4'h1) && (code == 3'd0) && !tmo) begin
      rec = '{DATA_A, 1'b0, 1'b1, 32'h0, 3'($urandom), r.rdData};
      expQ.push_back(rec);
      expRdata = r.rdData;
    end
    expRespDelay = r.respDelay;
  endfunction

  // Compare the current outputs with the model, then drive inputs for the
  // coming edge and advance the model across it.
  task automatic stepCycle();
    recT rec;
    reqT r;
    bit handshake;
    @(negedge clk);
    cyc++;
    handshake = 0;
    checkOutput("cmnd_op_hold", 32'(cmndOp), 32'(lastOp));
    checkOutput("cmnd_addr_hold", 32'(cmndAddr), 32'(lastAddr));
    if (!busy) begin
      checkOutput("idle_req_ready", 32'(reqReady), 32'd1);
      checkOutput("idle_rsp_valid", 32'(rspValid), 32'd0);
      checkOutput("idle_wr_stb", 32'(wrStb), 32'd0);
      checkOutput("idle_wr_dat", wrDat, 32'd0);
      statCode = 3'($urandom);
      rdDat = $urandom;
      rspReady = 1'($urandom);
    end else if (expQ.size() > 0) begin
      rec = expQ.pop_front();
      checkOutput("seq_req_ready", 32'(reqReady), 32'd0);
      checkOutput("seq_rsp_valid", 32'(rspValid), 32'd0);
      checkOutput("seq_reg_addr", 32'(regAddr), 32'(rec.addr));
      checkOutput("seq_wr_stb", 32'(wrStb), 32'(rec.stb));
      if (rec.chkDat) checkOutput("seq_wr_dat", wrDat, rec.dat);
      statCode = rec.stat;
      rdDat = rec.rd;
      rspReady = 1'($urandom);
    end else begin
      if (respCycles == 0) begin
        latency = cyc - acceptCyc;
        seenRdata = rspRdata;
        seenCode = rspCode;
        seenTimeout = rspTimeout;
      end
      checkOutput("rsp_valid", 32'(rspValid), 32'd1);
      checkOutput("rsp_req_ready", 32'(reqReady), 32'd0);
      checkOutput("rsp_wr_stb", 32'(wrStb), 32'd0);
      checkOutput("rsp_wr_dat", wrDat, 32'd0);
      checkOutput("rsp_rdata", rspRdata, expRdata);
      checkOutput("rsp_code", 32'(rspCode), 32'(expCode));
      checkOutput("rsp_timeout", 32'(rspTimeout), 32'(expTimeout));
      rspReady = (respCycles >= expRespDelay);
      handshake = rspReady;
      respCycles++;
      statCode = 3'($urandom);
      rdDat = $urandom;
    end
    reqValid = (reqQ.size() > 0);
    if (reqQ.size() > 0) begin
      reqOp = reqQ[0].op;
      reqAddr = reqQ[0].addr;
      reqWdata = reqQ[0].wdata;
    end else begin
      reqOp = 4'($urandom);
      reqAddr = 4'($urandom);
      reqWdata = $urandom;
    end
    if (handshake) begin
      busy = 1'b0;
      lastHandshakeCyc = cyc;
    end else if (!busy && (reqQ.size() > 0)) begin
      r = reqQ.pop_front();
      busy = 1'b1;
      lastOp = r.op;
      lastAddr = r.addr;
      buildTrace(r);
      acceptCyc = cyc;
      respCycles = 0;
      lastGap = cyc - lastHandshakeCyc;
    end
  endtask

  task automatic resetModel();
    busy = 1'b0;
    expQ.delete();
    reqQ.delete();
    lastOp = '0;
    lastAddr = '0;
    reqValid = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_req_ready"}, 32'(reqReady), 32'd1);
    checkOutput({tag, "_rsp_valid"}, 32'(rspValid), 32'd0);
    checkOutput({tag, "_rsp_rdata"}, rspRdata, 32'd0);
    checkOutput({tag, "_rsp_code"}, 32'(rspCode), 32'd0);
    checkOutput({tag, "_rsp_timeout"}, 32'(rspTimeout), 32'd0);
    checkOutput({tag, "_reg_addr"}, 32'(regAddr), 32'd0);
    checkOutput({tag, "_wr_stb"}, 32'(wrStb), 32'd0);
    checkOutput({tag, "_wr_dat"}, wrDat, 32'd0);
    checkOutput({tag, "_cmnd_op"}, 32'(cmndOp), 32'd0);
    checkOutput({tag, "_cmnd_addr"}, 32'(cmndAddr), 32'd0);
  endtask

  // Assert reset between clock edges and check outputs clear without an edge.
  task automatic resetMidCycle(input string tag);
    @(posedge clk);
    #2;
    rstN = 1'b0;
    #1;
    checkResetValues(tag);
    resetModel();
    repeat (2) @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic runUntilIdle(input int budget);
    int n;
    n = 0;
    while ((busy || (reqQ.size() > 0)) && (n < budget)) begin
      stepCycle();
      n++;
    end
    if (busy || (reqQ.size() > 0)) begin
      checks++;
      errors++;
      $display("[TB] FAIL run_budget: transaction still open after %0d cycles, required completion", budget);
      resetMidCycle("resync");
    end
  endtask

  function automatic reqT mkReq(input logic [3:0] op, input logic [3:0] addr, input logic [31:0] wdata,
                                input int busyCycles, input logic [2:0] finalCode,
                                input logic [31:0] rdData, input int respDelay);
    reqT r;
    r = '{op, addr, wdata, busyCycles, finalCode, rdData, respDelay};
    return r;
  endfunction

  initial begin
    reqT r;
    int pick;
    $display("[TB] start");
    #12;
    checkResetValues("reset");
    @(negedge clk);
    rstN = 1'b1;
    repeat (2) stepCycle();

    applyStimulus(mkReq(4'h2, 4'd3, 32'hA5A5_0001, 4, 3'd0, 32'hDEAD_0000, 0));
    runUntilIdle(100);
    checkOutput("write_latency", 32'(latency), 32'd9);
    checkOutput("write_code", 32'(seenCode), 32'd0);
    checkOutput("write_rdata", seenRdata, 32'd0);
    checkOutput("write_cmnd_op", 32'(cmndOp), 32'h2);
    checkOutput("write_cmnd_addr", 32'(cmndAddr), 32'd3);

    applyStimulus(mkReq(4'h1, 4'd5, 32'h0, 0, 3'd0, 32'h1234_5678, 1));
    runUntilIdle(100);
    checkOutput("read_latency", 32'(latency), 32'd5);
    checkOutput("read_rdata", seenRdata, 32'h1234_5678);
    checkOutput("read_code", 32'(seenCode), 32'd0);

    applyStimulus(mkReq(4'h1, 4'd6, 32'h0, 0, 3'd4, 32'h5555_AAAA, 0));
    runUntilIdle(100);
    checkOutput("rderr_latency", 32'(latency), 32'd4);
    checkOutput("rderr_code", 32'(seenCode), 32'd4);
    checkOutput("rderr_rdata", seenRdata, 32'd0);

`ifdef NX_INDIRECT_INITIATOR_TIMEOUT_EN
    applyStimulus(mkReq(4'h1, 4'd7, 32'h0, 1000, 3'd0, 32'h0BAD_0BAD, 0));
    runUntilIdle(100);
    checkOutput("timeout_latency", 32'(latency), 32'd10);
    checkOutput("timeout_flag", 32'(seenTimeout), 32'd1);
    checkOutput("timeout_code", 32'(seenCode), 32'd1);
`else
    applyStimulus(mkReq(4'h1, 4'd7, 32'h0, 20, 3'd0, 32'hCAFE_F00D, 0));
    runUntilIdle(100);
    checkOutput("longpoll_latency", 32'(latency), 32'd25);
    checkOutput("longpoll_timeout", 32'(seenTimeout), 32'd0);
    checkOutput("longpoll_rdata", seenRdata, 32'hCAFE_F00D);
`endif

    applyStimulus(mkReq(4'h2, 4'd9, 32'h1357_9BDF, 0, 3'd0, 32'h0, 10));
    applyStimulus(mkReq(4'h0, 4'd2, 32'h0, 1, 3'd0, 32'h0, 0));
    runUntilIdle(100);
    checkOutput("hold_next_accept_gap", 32'(lastGap), 32'd1);

    applyStimulus(mkReq(4'h1, 4'd4, 32'h0, 50, 3'd0, 32'h0, 0));
    repeat (5) stepCycle();
    resetMidCycle("midreset");
    applyStimulus(mkReq(4'h1, 4'd1, 32'h0, 1, 3'd0, 32'h8765_4321, 0));
    runUntilIdle(100);
    checkOutput("after_reset_latency", 32'(latency), 32'd6);
    checkOutput("after_reset_rdata", seenRdata, 32'h8765_4321);

    for (int i = 0; i < 40; i++) begin
      pick = $urandom_range(0, 3);
      r.op = (pick == 0) ? 4'h0 : (pick == 1) ? 4'h1 : (pick == 2) ? 4'h2 : 4'($urandom);
      r.addr = 4'($urandom);
      r.wdata = $urandom;
      r.busy = $urandom_range(0, 5);
      r.finalCode = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(2, 7)) : 3'd0;
      r.rdData = $urandom;
      r.respDelay = $urandom_range(0, 3);
      applyStimulus(r);
      if ($urandom_range(0, 3) != 0) runUntilIdle(200);
    end
    runUntilIdle(2000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
